// File: rtl/kit_v_pkg.sv
// kit_v_pkg: shared types, constants and the self-test data pattern for the kit harness.
package kit_v_pkg;

    typedef enum logic [1:0] {FILL, VERIFY, DONE} state_t;

    localparam logic [7:0] DONE_TAG = 8'hD0;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a, ~a};
    endfunction

endpackage

// File: rtl/kit_v_clkdiv.sv
// kit_v_clkdiv: registered kit clocks derived from the board clock, plus the 1 MHz tick enable.
module kit_v_clkdiv #(
    parameter int DIV_1MHZ = 50,
    parameter int DIV_1KHZ = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_25,
    output logic clk_1m,
    output logic clk_1k,
    output logic tick
);
    localparam int W1 = $clog2(DIV_1MHZ);
    localparam int W2 = $clog2(DIV_1KHZ);

    logic [W1-1:0] c1;
    logic [W2-1:0] c2;
    logic wrap1, wrap2;

    assign wrap1 = (c1 == W1'(DIV_1MHZ - 1));
    assign wrap2 = (c2 == W2'(DIV_1KHZ - 1));
    assign tick = wrap1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1     <= '0;
            c2     <= '0;
            clk_25 <= 1'b0;
            clk_1m <= 1'b0;
            clk_1k <= 1'b0;
        end else begin
            c1     <= wrap1 ? '0 : c1 + 1'b1;
            c2     <= wrap2 ? '0 : c2 + 1'b1;
            clk_25 <= ~clk_25;
            clk_1m <= (c1 < W1'(DIV_1MHZ / 2));
            clk_1k <= (c2 < W2'(DIV_1KHZ / 2));
        end
    end

endmodule

// File: rtl/kit_v_top.sv
// kit_v_top: kit clock outputs and a built-in RAM fill/verify self-test paced by the 1 MHz tick.
module kit_v_top
    import kit_v_pkg::*;
#(
    parameter int DIV_1MHZ = 50,
    parameter int DIV_1KHZ = 50000,
    parameter int RAM_AW   = 8
) (
    input  logic        clock__50Mhz,
    input  logic        reset_n,
    output logic        wire_clock_50Mhz,
    output logic        wire_clock_25Mhz,
    output logic        wire_clock_1MHz,
    output logic        wire_clock_1KHz,
    output logic [15:0] bus_RAM_ADDRESS,
    output logic [15:0] bus_RAM_DATA_OUT,
    output logic        wire_RW,
    output logic [15:0] bus_RAM_DATA_IN,
    output logic [15:0] data_debug
);
    state_t state, state_next;
    logic tick, last;
    logic [RAM_AW-1:0] addr;
    logic [7:0] err;
    logic [15:0] latched, addr_ext, expect_word;
    logic [15:0] mem [2**RAM_AW];

    kit_v_clkdiv #(.DIV_1MHZ(DIV_1MHZ), .DIV_1KHZ(DIV_1KHZ)) clkdiv (
        .clk   (clock__50Mhz),
        .rst_n (reset_n),
        .clk_25(wire_clock_25Mhz),
        .clk_1m(wire_clock_1MHz),
        .clk_1k(wire_clock_1KHz),
        .tick  (tick)
    );

    assign wire_clock_50Mhz = clock__50Mhz;
    assign addr_ext         = 16'(addr);
    assign expect_word      = pat(addr_ext[7:0]);
    assign last             = &addr;
    assign bus_RAM_ADDRESS  = addr_ext;
    assign bus_RAM_DATA_IN  = expect_word;
    assign wire_RW          = (state == FILL);
    assign data_debug       = (state == DONE) ? {DONE_TAG, err} : latched;

    always_comb begin
        state_next = state;
        if (tick && last && state != DONE)
            state_next = (state == FILL) ? VERIFY : DONE;
    end

    always_ff @(posedge clock__50Mhz or negedge reset_n) begin
        if (!reset_n)
            state <= FILL;
        else
            state <= state_next;
    end

    // Address wraps to 0 on the final tick of VERIFY, which is the DONE address.
    always_ff @(posedge clock__50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            addr    <= '0;
            err     <= '0;
            latched <= '0;
        end else if (tick && state != DONE) begin
            addr <= addr + 1'b1;
            if (state == VERIFY) begin
                latched <= bus_RAM_DATA_OUT;
                if (bus_RAM_DATA_OUT != expect_word && err != 8'hFF)
                    err <= err + 1'b1;
            end
        end
    end

    always_ff @(posedge clock__50Mhz) begin
        if (tick && state == FILL)
            mem[addr] <= expect_word;
    end

    always_ff @(posedge clock__50Mhz or negedge reset_n) begin
        if (!reset_n)
            bus_RAM_DATA_OUT <= '0;
        else
            bus_RAM_DATA_OUT <= mem[addr];
    end

endmodule

// File: tb/tb_kit_v_top.sv
// tb_kit_v_top: checks two kit_v_top instances (default and DIV_1MHZ=4) against a cycle-count model.
module tb_kit_v_top;

    typedef struct packed {
        logic        c25;
        logic        c1m;
        logic        c1k;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] dbg;
    } obs_t;

    localparam obs_t RESET_OBS = '{c25: 1'b0, c1m: 1'b0, c1k: 1'b0, rw: 1'b1, addr: 16'h0, dbg: 16'h0};

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0;
    logic a_c50, a_c25, a_c1m, a_c1k, a_rw;
    logic b_c50, b_c25, b_c1m, b_c1k, b_rw;
    logic [15:0] a_addr, a_dout, a_din, a_dbg;
    logic [15:0] b_addr, b_dout, b_din, b_dbg;
    int total = 0, bad = 0;

    kit_v_top dut_a (
        .clock__50Mhz(clk), .reset_n(rst_a),
        .wire_clock_50Mhz(a_c50), .wire_clock_25Mhz(a_c25), .wire_clock_1MHz(a_c1m), .wire_clock_1KHz(a_c1k),
        .bus_RAM_ADDRESS(a_addr), .bus_RAM_DATA_OUT(a_dout), .wire_RW(a_rw),
        .bus_RAM_DATA_IN(a_din), .data_debug(a_dbg)
    );

    kit_v_top #(.DIV_1MHZ(4)) dut_b (
        .clock__50Mhz(clk), .reset_n(rst_b),
        .wire_clock_50Mhz(b_c50), .wire_clock_25Mhz(b_c25), .wire_clock_1MHz(b_c1m), .wire_clock_1KHz(b_c1k),
        .bus_RAM_ADDRESS(b_addr), .bus_RAM_DATA_OUT(b_dout), .wire_RW(b_rw),
        .bus_RAM_DATA_IN(b_din), .data_debug(b_dbg)
    );

    function automatic logic [15:0] pat_m(input int a);
        return 16'(a * 256 + (255 - a));
    endfunction

    // Expected outputs t cycles after reset release: one tick every d cycles, 256 fill ticks, 256 verify ticks.
    function automatic obs_t model(input int d, input int t);
        obs_t e;
        int k;
        k = t / d;
        e.c25 = (t % 2) == 1;
        e.c1m = t >= 1 && ((t - 1) % d) < d / 2;
        e.c1k = t >= 1 && ((t - 1) % 50000) < 25000;
        if (k < 256) begin
            e.rw = 1'b1; e.addr = 16'(k); e.dbg = 16'h0;
        end else if (k < 512) begin
            e.rw = 1'b0; e.addr = 16'(k - 256); e.dbg = (k == 256) ? 16'h0 : pat_m(k - 257);
        end else begin
            e.rw = 1'b0; e.addr = 16'h0; e.dbg = 16'hD000;
        end
        return e;
    endfunction

    function automatic obs_t obs(input bit b);
        obs_t o;
        o = b ? {b_c25, b_c1m, b_c1k, b_rw, b_addr, b_dbg} : {a_c25, a_c1m, a_c1k, a_rw, a_addr, a_dbg};
        return o;
    endfunction

    task automatic test_reset();
        obs_t got;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            got = obs(b[0]);
            total++;
            if (got !== RESET_OBS) begin bad++; $display("FAIL reset_init%0d got=%h expected=%h", b, got, RESET_OBS); end
            total++;
            if ((b ? b_dout : a_dout) !== 16'h0) begin bad++; $display("FAIL reset_init_dout%0d got=%h expected=0000", b, b ? b_dout : a_dout); end
            total++;
            if ((b ? b_din : a_din) !== 16'h00FF) begin bad++; $display("FAIL reset_init_din%0d got=%h expected=00ff", b, b ? b_din : a_din); end
        end
        rst_a = 1'b1;
        repeat ($urandom_range(3000, 100)) @(negedge clk);
        #5 rst_a = 1'b0;
        #1;
        got = obs(1'b0);
        total++;
        if (got !== RESET_OBS) begin bad++; $display("FAIL reset_async got=%h expected=%h", got, RESET_OBS); end
        total++;
        if (a_dout !== 16'h0 || a_din !== 16'h00FF) begin bad++; $display("FAIL reset_async_bus dout=%h din=%h expected dout=0000 din=00ff", a_dout, a_din); end
        @(posedge clk); #1;
        total++;
        if (a_c50 !== 1'b1) begin bad++; $display("FAIL clk50_copy_high got=%b expected=1", a_c50); end
    endtask

    task automatic test_default_run();
        obs_t got, exp;
        int fails = 0, k;
        int ph[2] = '{0, 0}, hi[2] = '{0, 0}, lo[2] = '{0, 0};
        logic s[2];
        @(negedge clk);
        rst_a = 1'b1;
        for (int t = 0; t <= 50001 && fails < 20; t++) begin
            if (t > 0) @(negedge clk);
            k = t / 50;
            got = obs(1'b0);
            exp = model(50, t);
            total++;
            if (got !== exp) begin bad++; fails++; $display("FAIL default_run t=%0d got=%h expected=%h", t, got, exp); end
            if (k < 256) begin
                total++;
                if (a_din !== pat_m(k)) begin bad++; fails++; $display("FAIL default_fill_din t=%0d got=%h expected=%h", t, a_din, pat_m(k)); end
            end else if (k < 512 && t % 50 != 0) begin
                total++;
                if (a_dout !== pat_m(k - 256)) begin bad++; fails++; $display("FAIL default_verify_dout t=%0d got=%h expected=%h", t, a_dout, pat_m(k - 256)); end
            end
            total++;
            if (a_c50 !== clk) begin bad++; fails++; $display("FAIL clk50_copy t=%0d got=%b expected=%b", t, a_c50, clk); end
            if (t == (257 + 8'h12) * 50 + 1) begin
                total++;
                if (a_dbg !== 16'h12ED) begin bad++; $display("FAIL debug_12 got=%h expected=12ed", a_dbg); end
            end
            if (t == 25601) begin
                total++;
                if (a_dbg !== 16'hD000 || a_addr !== 16'h0 || a_rw !== 1'b0) begin
                    bad++; $display("FAIL default_pass dbg=%h addr=%h rw=%b expected d000/0000/0", a_dbg, a_addr, a_rw);
                end
            end
            s[0] = a_c1m;
            s[1] = a_c1k;
            for (int i = 0; i < 2; i++) begin
                if (ph[i] == 0 && s[i]) ph[i] = 1;
                if (ph[i] == 1) begin if (s[i]) hi[i]++; else ph[i] = 2; end
                if (ph[i] == 2) begin if (!s[i]) lo[i]++; else ph[i] = 3; end
            end
        end
        total++;
        if (hi[0] != 25 || lo[0] != 25) begin bad++; $display("FAIL div_1mhz high=%0d low=%0d expected 25/25", hi[0], lo[0]); end
        total++;
        if (hi[1] != 25000 || lo[1] != 25000) begin bad++; $display("FAIL div_1khz high=%0d low=%0d expected 25000/25000", hi[1], lo[1]); end
    endtask

    task automatic test_scaled();
        obs_t got, exp;
        int fails = 0, k;
        @(negedge clk);
        rst_b = 1'b1;
        for (int t = 0; t <= 2100 && fails < 20; t++) begin
            if (t > 0) @(negedge clk);
            k = t / 4;
            got = obs(1'b1);
            exp = model(4, t);
            total++;
            if (got !== exp) begin bad++; fails++; $display("FAIL scaled_run t=%0d got=%h expected=%h", t, got, exp); end
            if (k < 256) begin
                total++;
                if (b_din !== pat_m(k)) begin bad++; fails++; $display("FAIL scaled_fill_din t=%0d got=%h expected=%h", t, b_din, pat_m(k)); end
            end else if (k < 512 && t % 4 != 0) begin
                total++;
                if (b_dout !== pat_m(k - 256)) begin bad++; fails++; $display("FAIL scaled_verify_dout t=%0d got=%h expected=%h", t, b_dout, pat_m(k - 256)); end
            end
            if (t == 2047) begin
                total++;
                if (b_dbg !== 16'hFE01) begin bad++; $display("FAIL scaled_before_done got=%h expected=fe01", b_dbg); end
            end
            if (t == 2048) begin
                total++;
                if (b_dbg !== 16'hD000 || b_addr !== 16'h0) begin bad++; $display("FAIL scaled_done dbg=%h addr=%h expected d000/0000", b_dbg, b_addr); end
                total++;
                if (dut_b.latched !== 16'hFF00) begin bad++; $display("FAIL scaled_last_compare got=%h expected=ff00", dut_b.latched); end
            end
        end
    endtask

    task automatic test_reset_mid_verify();
        obs_t got, exp;
        int fails = 0, target;
        rst_b = 1'b0;
        repeat ($urandom_range(4, 1)) @(negedge clk);
        rst_b = 1'b1;
        target = (256 + 8'h40) * 4 + $urandom_range(3, 0);
        repeat (target) @(negedge clk);
        total++;
        if (b_addr !== 16'h0040 || b_rw !== 1'b0) begin bad++; $display("FAIL mid_verify_pos addr=%h rw=%b expected 0040/0", b_addr, b_rw); end
        #5 rst_b = 1'b0;
        #1;
        got = obs(1'b1);
        total++;
        if (got !== RESET_OBS) begin bad++; $display("FAIL mid_verify_reset got=%h expected=%h", got, RESET_OBS); end
        repeat ($urandom_range(3, 1)) @(negedge clk);
        rst_b = 1'b1;
        for (int t = 0; t <= 2100 && fails < 20; t++) begin
            if (t > 0) @(negedge clk);
            got = obs(1'b1);
            exp = model(4, t);
            total++;
            if (got !== exp) begin bad++; fails++; $display("FAIL restart_run t=%0d got=%h expected=%h", t, got, exp); end
        end
        total++;
        if (b_dbg !== 16'hD000) begin bad++; $display("FAIL restart_pass got=%h expected=d000", b_dbg); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_scaled();
        test_reset_mid_verify();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
